ps2_key_serializer: RTL and testbench
=====================================

Name: ps2_key_serializer

Overview:
- Converts the hps_io `ps2_key` event word into a device-side PS/2 keyboard clock/data stream.
- Output drives the `ps2_clk`/`ps2_data` inputs of the `pc8001m` core, which are currently unconnected at the top level.
- Sits directly upstream of `pc8001m`, clocked by `clk_sys` (28.63636 MHz).
- Buffers make/break/extended byte sequences in a small FIFO and emits standard 11-bit PS/2 frames at keyboard bit rate.

Parameters:
- FIFO_DEPTH, 16, byte FIFO depth; power of two, minimum 4.
- CLK_HALF, 1145, clk_sys cycles per PS/2 clock half-period (about 12.5 kHz bit rate at 28.636 MHz).
- GAP_CYCLES, 2290, idle clk_sys cycles between consecutive frames, both lines high.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [8] extended, [7:0] set-2 scancode
- ps2_clk  out  1  PS/2 clock to pc8001m; idle high
- ps2_data  out  1  PS/2 data to pc8001m; idle high
- busy  out  1  high while a frame or inter-frame gap is in progress, or the FIFO is non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; set when an event is dropped, cleared only by reset

Behaviour:
- Reset values (asynchronous, reset_n=0): ps2_clk=1, ps2_data=1, busy=0, fifo_level=0, overflow=0, toggle_q=0, FSM=IDLE, FIFO empty. Reset aborts any frame in progress immediately.
- Event detect: toggle_q registers ps2_key[10] every cycle. An event occurs when ps2_key[10] differs from toggle_q, and is evaluated on the same cycle.
- Event byte sequence, in order:
  - 0xE0 if [8]=1;
  - then 0xF0 if [9]=0;
  - then [7:0].
  - Result is 1–3 bytes.
- FIFO write: the whole sequence is written atomically on the event cycle; the FIFO has 3 parallel write lanes.
  - If free slots are fewer than the sequence length, the entire event is dropped and overflow is set.
  - A partial sequence is never written.
- FIFO pointers wrap modulo FIFO_DEPTH. If a read and a write occur in the same cycle, fifo_level = level + n_written - 1.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty, pop a byte into shift register sh[10:0] = {1, ~^byte, byte[7:0], 0}, set bit_idx=0, go to HI.
  - HI: ps2_clk=1, ps2_data=sh[bit_idx], hold CLK_HALF cycles, then go to LO.
  - LO: ps2_clk=0, ps2_data unchanged, hold CLK_HALF cycles.
    - If bit_idx=10: go to GAP.
    - Otherwise: bit_idx+1, go to HI.
  - GAP: ps2_clk=1, ps2_data=1, hold GAP_CYCLES cycles, then go to IDLE.
- Frame format: data bits LSB first; the parity bit is odd parity (makes the total count of ones across the data and parity bits odd). One frame lasts exactly 22*CLK_HALF cycles plus GAP_CYCLES.
- Data changes only while ps2_clk is high; the host samples on the falling edge of ps2_clk.
- Latency: with the FSM in IDLE and the FIFO empty, ps2_data falls to the start bit 2 cycles after the event cycle (event cycle N, FIFO valid N+1, HI entered N+2).
- Events arriving mid-frame are queued and never disturb the frame being sent.
- The half-period counter is a single down-counter reloaded on every state entry; its width is sized for max(CLK_HALF, GAP_CYCLES).
- Outputs ps2_clk and ps2_data are driven directly from registers (glitch-free, no combinational path from ps2_key).
- busy = (FSM != IDLE) | (fifo_level != 0).
- Out of scope: host-to-device commands; typematic repeat, which is the source's responsibility; special handling of Pause/PrintScreen multi-byte codes, which are passed through literally as delivered.

Test Plan:
- Toggle 0→1 with ps2_key = {1,1,0,0x1C} (press A):
  - one frame on ps2_data at falling edges: 0,0,0,1,1,1,0,0,0,0,1;
  - start bit appears 2 cycles after the event;
  - frame is 22*CLK_HALF cycles;
  - then busy=0 after GAP_CYCLES.
- Release extended Right Arrow, ps2_key = {t,0,1,0x74}:
  - three frames in order: 0xE0 (parity 0), 0xF0 (parity 1), 0x74 (parity 1);
  - GAP_CYCLES of both lines high between frames;
  - fifo_level steps 3→2→1→0.
- Six toggles within 100 cycles with FIFO_DEPTH=4, each a non-extended release (2 bytes each):
  - the first two events are accepted (4 bytes);
  - the third event is dropped while fifo_level is 3 or 4;
  - overflow=1 and stays 1;
  - emitted byte stream contains no partial E0/F0 sequence.
- Event arriving during the LO phase of bit 5: the current frame completes unchanged, and the queued byte starts after the gap.
- reset_n low during bit 4 of a frame: ps2_clk=1, ps2_data=1, fifo_level=0, overflow=0 asynchronously; after release, no residual frame is sent.
- Event written on the same cycle the FSM pops the last byte: fifo_level ends at (event length), with no loss or duplication.

Source files
------------

// File: rtl/ps2_key_serializer.sv
// Purpose: turns hps_io ps2_key toggle events into device-side PS/2 keyboard frames (11-bit, odd parity).
// Latency: start bit appears on ps2_data 2 clk_sys cycles after the event cycle when idle with an empty FIFO.
// Backpressure: none upstream; events that do not fit in the byte FIFO are dropped whole and flag overflow.
//
// Ports:
//   clk_sys    - system clock
//   reset_n    - asynchronous active-low reset; aborts any frame in progress
//   ps2_key    - [10] toggle, [9] pressed, [8] extended, [7:0] set-2 scancode
//   ps2_clk    - PS/2 clock to the core, registered, idle high
//   ps2_data   - PS/2 data to the core, registered, idle high
//   busy       - frame or gap in progress, or bytes still queued
//   fifo_level - current byte FIFO occupancy
//   overflow   - sticky, set when an event was dropped
module ps2_key_serializer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_HALF   = 1145,
    parameter int GAP_CYCLES = 2290
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic [10:0]                   ps2_key,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int CNT_MAX = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] DEPTH_LW  = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_GAP
    } state_t;

    state_t          state;
    logic            toggle_q;
    logic            evt;
    logic [7:0]      lane0_dat;
    logic [7:0]      lane1_dat;
    logic [7:0]      lane2_dat;
    logic [1:0]      n_bytes;
    logic [1:0]      n_wr;
    logic [LW-1:0]   free_slots;
    logic            wr_en;
    logic            pop;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [7:0]      pop_dat;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_idx;
    logic [10:0]     sh;

    // An event is a change of the toggle bit relative to last cycle's copy.
    assign evt = ps2_key[10] ^ toggle_q;

    // Build the 1..3 byte sequence: optional E0 prefix, optional F0 break, then the code.
    always_comb begin
        lane0_dat = ps2_key[7:0];
        lane1_dat = 8'h00;
        lane2_dat = 8'h00;
        n_bytes   = 2'd1;
        case ({ps2_key[8], ~ps2_key[9]})
            2'b11: begin
                lane0_dat = 8'hE0;
                lane1_dat = 8'hF0;
                lane2_dat = ps2_key[7:0];
                n_bytes   = 2'd3;
            end
            2'b10: begin
                lane0_dat = 8'hE0;
                lane1_dat = ps2_key[7:0];
                n_bytes   = 2'd2;
            end
            2'b01: begin
                lane0_dat = 8'hF0;
                lane1_dat = ps2_key[7:0];
                n_bytes   = 2'd2;
            end
            default: begin
                lane0_dat = ps2_key[7:0];
                n_bytes   = 2'd1;
            end
        endcase
    end

    // Room is judged on the current level only, so a same-cycle pop never
    // lets an event in that would not have fit a cycle earlier.
    assign free_slots = DEPTH_LW - fifo_level;
    assign wr_en      = evt && (LW'(n_bytes) <= free_slots);
    assign n_wr       = wr_en ? n_bytes : 2'd0;
    assign pop        = (state == S_IDLE) && (fifo_level != '0);
    assign pop_dat    = mem[rd_ptr];
    assign busy       = (state != S_IDLE) || (fifo_level != '0);

    // Storage has no reset: emptiness is tracked by the pointers and level.
    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_ptr] <= lane0_dat;
            if (n_bytes >= 2'd2) begin
                mem[wr_ptr + AW'(1)] <= lane1_dat;
            end
            if (n_bytes == 2'd3) begin
                mem[wr_ptr + AW'(2)] <= lane2_dat;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            toggle_q   <= ps2_key[10];
            wr_ptr     <= wr_ptr + AW'(n_wr);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + LW'(n_wr) - LW'(pop);
            if (evt && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame sequencer. Each HI/LO phase lasts CLK_HALF cycles; data only
    // changes on entry to HI so it is stable across the falling edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            sh       <= '1;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    if (pop) begin
                        sh       <= {1'b1, ~^pop_dat, pop_dat, 1'b0};
                        bit_idx  <= 4'd0;
                        cnt      <= HALF_LOAD;
                        ps2_data <= 1'b0;
                        state    <= S_HI;
                    end
                end
                S_HI: begin
                    if (cnt == '0) begin
                        ps2_clk <= 1'b0;
                        cnt     <= HALF_LOAD;
                        state   <= S_LO;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_LO: begin
                    if (cnt == '0) begin
                        ps2_clk <= 1'b1;
                        if (bit_idx == 4'd10) begin
                            ps2_data <= 1'b1;
                            cnt      <= GAP_LOAD;
                            state    <= S_GAP;
                        end else begin
                            ps2_data <= sh[bit_idx + 4'd1];
                            bit_idx  <= bit_idx + 4'd1;
                            cnt      <= HALF_LOAD;
                            state    <= S_HI;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_serializer.sv
module tb_ps2_key_serializer;

    localparam int DEPTH = 4;
    localparam int CH    = 6;
    localparam int GAP   = 10;

    // Expected frames, bit k = k-th bit sampled on a falling ps2_clk edge.
    localparam logic [10:0] FR_1C = 11'b1_0_00011100_0;
    localparam logic [10:0] FR_E0 = 11'b1_0_11100000_0;
    localparam logic [10:0] FR_F0 = 11'b1_1_11110000_0;
    localparam logic [10:0] FR_74 = 11'b1_1_01110100_0;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic        ps2_clk;
    logic        ps2_data;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        overflow;

    int n_chk  = 0;
    int n_pass = 0;

    ps2_key_serializer #(
        .FIFO_DEPTH (DEPTH),
        .CLK_HALF   (CH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk_sys);
    endtask

    // Flip the toggle bit with new payload, then advance past the event edge.
    task automatic fire(input logic [9:0] v);
        ps2_key = {~ps2_key[10], v};
        step();
    endtask

    // Collect one frame by sampling ps2_data at each ps2_clk fall; returns once
    // the line is back high after the 11th fall. Optionally fires an event after
    // fall number inject_at.
    task automatic rx(input int inject_at, input logic [9:0] inj,
                      output logic [10:0] bits, output int steps);
        int   falls;
        logic prev;
        bits  = '0;
        falls = 0;
        steps = 0;
        prev  = ps2_clk;
        while (!(falls == 11 && ps2_clk == 1'b1) && steps < 2000) begin
            step();
            steps++;
            if (prev && !ps2_clk) begin
                bits[falls] = ps2_data;
                falls++;
                if (falls == inject_at) ps2_key = {~ps2_key[10], inj};
            end
            prev = ps2_clk;
        end
        if (steps >= 2000) chk("rx_timeout", falls, 11);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        logic [10:0] fr;
        int          cyc;
        int          bad;
        int          falls;
        logic        prev;

        // Reset state
        step();
        step();
        chk("rst_clk", ps2_clk, 1);
        chk("rst_data", ps2_data, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        step();
        step();

        // Press A: one frame, 2-cycle latency, 22*CH frame, then gap
        fire({1'b1, 1'b0, 8'h1C});
        chk("a_level_n1", fifo_level, 1);
        chk("a_data_n1", ps2_data, 1);
        step();
        chk("a_start_bit", ps2_data, 0);
        chk("a_clk_hi", ps2_clk, 1);
        chk("a_level_pop", fifo_level, 0);
        rx(0, '0, fr, cyc);
        chk("a_frame", fr, FR_1C);
        chk("a_frame_len", cyc, 22 * CH);
        bad = 0;
        for (int i = 0; i < GAP - 1; i++) begin
            if (!ps2_clk || !ps2_data) bad++;
            step();
        end
        chk("a_gap_lines", bad, 0);
        chk("a_busy_in_gap", busy, 1);
        step();
        chk("a_busy_after_gap", busy, 0);

        // Release extended right arrow: E0 F0 74
        fire({1'b0, 1'b1, 8'h74});
        chk("rel_level3", fifo_level, 3);
        rx(0, '0, fr, cyc);
        chk("rel_fr_e0", fr, FR_E0);
        chk("rel_level2", fifo_level, 2);
        rx(0, '0, fr, cyc);
        chk("rel_fr_f0", fr, FR_F0);
        chk("rel_level1", fifo_level, 1);
        rx(0, '0, fr, cyc);
        chk("rel_fr_74", fr, FR_74);
        chk("rel_level0", fifo_level, 0);
        wait_idle();

        // Event during LO of bit 5 queues behind the running frame
        fire({1'b1, 1'b0, 8'h1C});
        rx(6, {1'b1, 1'b0, 8'h74}, fr, cyc);
        chk("mid_frame_intact", fr, FR_1C);
        chk("mid_queued", fifo_level, 1);
        rx(0, '0, fr, cyc);
        chk("mid_next_frame", fr, FR_74);
        wait_idle();

        // Same-cycle pop of the last byte and 3-byte write
        fire({1'b1, 1'b0, 8'h1C});
        chk("sc_level1", fifo_level, 1);
        fire({1'b0, 1'b1, 8'h74});
        chk("sc_level3", fifo_level, 3);
        rx(0, '0, fr, cyc);
        chk("sc_fr0", fr, FR_1C);
        rx(0, '0, fr, cyc);
        chk("sc_fr1", fr, FR_E0);
        rx(0, '0, fr, cyc);
        chk("sc_fr2", fr, FR_F0);
        rx(0, '0, fr, cyc);
        chk("sc_fr3", fr, FR_74);
        wait_idle();
        chk("sc_ovf", overflow, 0);

        // Overflow: six back-to-back 2-byte releases into a 4-deep FIFO
        fire({1'b0, 1'b0, 8'h1C});
        fire({1'b0, 1'b0, 8'h1C});
        fire({1'b0, 1'b0, 8'h1C});
        chk("ovf_level3", fifo_level, 3);
        chk("ovf_set", overflow, 1);
        fire({1'b0, 1'b0, 8'h1C});
        fire({1'b0, 1'b0, 8'h1C});
        fire({1'b0, 1'b0, 8'h1C});
        rx(0, '0, fr, cyc);
        chk("ovf_fr0", fr, FR_F0);
        rx(0, '0, fr, cyc);
        chk("ovf_fr1", fr, FR_1C);
        rx(0, '0, fr, cyc);
        chk("ovf_fr2", fr, FR_F0);
        rx(0, '0, fr, cyc);
        chk("ovf_fr3", fr, FR_1C);
        wait_idle();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_level0", fifo_level, 0);

        // Reset in the middle of bit 4 with a byte still queued
        fire({1'b1, 1'b0, 8'h1C});
        fire({1'b1, 1'b0, 8'h74});
        falls = 0;
        cyc   = 0;
        prev  = ps2_clk;
        while (falls < 4 && cyc < 500) begin
            step();
            cyc++;
            if (prev && !ps2_clk) falls++;
            prev = ps2_clk;
        end
        while (!ps2_clk && cyc < 500) begin
            step();
            cyc++;
        end
        chk("rst_mid_reached_bit4", falls, 4);
        chk("rst_mid_pre_level", fifo_level, 1);
        ps2_key = '0;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_clk", ps2_clk, 1);
        chk("rst_mid_data", ps2_data, 1);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_ovf", overflow, 0);
        chk("rst_mid_busy", busy, 0);
        step();
        step();
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (!ps2_clk || !ps2_data || busy) bad++;
        end
        chk("rst_no_residual", bad, 0);
        chk("rst_post_level", fifo_level, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
